remove_cp: RTL

Receive-side cyclic prefix removal for the OFDM chain. Accepts a continuous stream of complex time-domain samples framed as symbols of LCP+NFFT samples, discards the first LCP samples (the prefix) of each symbol and forwards the NFFT body samples to the receive FFT. Flow control is valid/ready on both sides, with a single-entry output register. A symbol-start strobe acquires and re-acquires framing.

---
 rtl/remove_cp.sv | 107 ++++++++++
 1 files changed

// File: rtl/remove_cp.sv
// Receive-side cyclic prefix removal: drops the first LCP samples of every LCP+NFFT symbol
// and forwards the NFFT body samples through a single-entry valid/ready output register.
module remove_cp #(
  parameter int LCP  = 16,
  parameter int NFFT = 48,
  parameter int DW   = 16
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic [DW-1:0] DAT_I_r,
  input  logic [DW-1:0] DAT_I_i,
  input  logic          VLD_I,
  input  logic          SOF_I,
  output logic          RDY_O,
  output logic [DW-1:0] DAT_O_r,
  output logic [DW-1:0] DAT_O_i,
  output logic          VLD_O,
  output logic          SOF_O,
  output logic          EOF_O,
  input  logic          RDY_I,
  output logic [15:0]   SYM_CNT_O,
  output logic          ERR_O
);

  localparam logic [9:0] CNT_CP_LAST = 10'(LCP - 1);
  localparam logic [9:0] CNT_BODY0   = 10'(LCP);
  localparam logic [9:0] CNT_LAST    = 10'(LCP + NFFT - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CP   = 2'd1;
  localparam logic [1:0] ST_BODY = 2'd2;

  logic [1:0] state;
  logic [9:0] cnt;
  logic       accept;
  logic       xfer;
  logic       sof_restart;
  logic       resync;
  logic       load;
  logic [1:0] restart_state;

  // NOTE: RDY_O is gated by RST_I so nothing is handshaken while the block is held in reset.
  assign RDY_O  = ~RST_I & ((state != ST_BODY) | ~VLD_O | RDY_I);
  assign accept = VLD_I & RDY_O;
  assign xfer   = VLD_O & RDY_I;

  // A SOF anywhere other than an expected symbol boundary (re)starts framing at CP sample 0.
  assign sof_restart   = accept & SOF_I & ((state == ST_IDLE) | (cnt != '0));
  assign resync        = sof_restart & (state != ST_IDLE);
  assign load          = accept & ~sof_restart & (state == ST_BODY);
  assign restart_state = (LCP == 1) ? ST_BODY : ST_CP;

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      SYM_CNT_O <= '0;
      ERR_O     <= 1'b0;
    end else begin
      ERR_O <= resync;
      if (sof_restart) begin
        state <= restart_state;
        cnt   <= 10'd1;
      end else if (accept) begin
        case (state)
          ST_CP: begin
            cnt <= cnt + 10'd1;
            if (cnt == CNT_CP_LAST) state <= ST_BODY;
          end
          ST_BODY: begin
            if (cnt == CNT_LAST) begin
              cnt       <= '0;
              state     <= ST_CP;
              SYM_CNT_O <= SYM_CNT_O + 16'd1;
            end else begin
              cnt <= cnt + 10'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Single-entry output register; a load in the same cycle as a transfer simply replaces it.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      DAT_O_r <= '0;
      DAT_O_i <= '0;
      VLD_O   <= 1'b0;
      SOF_O   <= 1'b0;
      EOF_O   <= 1'b0;
    end else if (load) begin
      DAT_O_r <= DAT_I_r;
      DAT_O_i <= DAT_I_i;
      VLD_O   <= 1'b1;
      SOF_O   <= (cnt == CNT_BODY0);
      EOF_O   <= (cnt == CNT_LAST);
    end else if (xfer) begin
      VLD_O <= 1'b0;
      SOF_O <= 1'b0;
      EOF_O <= 1'b0;
    end
  end

endmodule
